// File: rtl/sample_buf_ctrl.sv
// Ping-pong write/read address sequencer for the I/Q sample RAMs ahead of the timing estimator.
// Optional build macro: SAMPLE_BUF_DROP_CNT_EN (saturating dropped-sample counter on drop_cnt).
module sample_buf_ctrl #(
  parameter int DW      = 16,
  parameter int BLK_LEN = 256,
  parameter int AW      = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din_i,
  input  logic [DW-1:0] din_q,
  input  logic          din_valid,
  output logic          we,
  output logic [AW-1:0] addr_a,
  output logic [DW-1:0] din_a_i,
  output logic [DW-1:0] din_a_q,
  output logic [AW-1:0] addr_b,
  input  logic          om_ready,
  output logic          rd_valid,
  output logic          rd_sof,
  output logic          rd_eof,
  output logic          ovf,
  output logic [15:0]   drop_cnt
);

  localparam int CW = AW - 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BLK_LEN - 1);

  typedef enum logic [1:0] {R_IDLE, R_RUN, R_LAST} rstate_t;

  rstate_t       state, state_nxt;
  logic          wr_bank, rd_bank;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [1:0]    full, full_nxt;
  logic [AW-1:0] addr_b_hold;
  logic          drop, wr_last, issue, rd_done, rd_start;

  // Write side: the RAM registers these, so they pass straight through.
  assign we      = din_valid & ~full[wr_bank] & ~rst;
  assign drop    = din_valid & full[wr_bank];
  assign wr_last = we & (wr_cnt == LAST_CNT);
  assign addr_a  = {wr_bank, wr_cnt};
  assign din_a_i = din_i;
  assign din_a_q = din_q;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    rd_done   = 1'b0;
    rd_start  = 1'b0;
    case (state)
      R_IDLE: begin
        if (full[rd_bank]) begin
          state_nxt = R_RUN;
          rd_start  = 1'b1;
        end
      end
      R_RUN: begin
        issue = om_ready;
        if (om_ready && (rd_cnt == LAST_CNT)) state_nxt = R_LAST;
      end
      R_LAST: begin
        rd_done   = 1'b1;
        state_nxt = R_IDLE;
      end
      default: state_nxt = R_IDLE;
    endcase
  end

  // Set and clear always hit different banks, so both can apply in one cycle.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
  end

  assign addr_b = (state == R_RUN) ? {rd_bank, rd_cnt} : addr_b_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= R_IDLE;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      full        <= 2'b00;
      addr_b_hold <= '0;
      rd_valid    <= 1'b0;
      rd_sof      <= 1'b0;
      rd_eof      <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state       <= state_nxt;
      full        <= full_nxt;
      addr_b_hold <= addr_b;
      if (we) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (rd_start) rd_cnt <= '0;
      else if (issue) rd_cnt <= rd_cnt + 1'b1;
      if (rd_done) rd_bank <= ~rd_bank;
      // Markers are delayed one cycle to line up with the RAM read data.
      rd_valid <= issue;
      rd_sof   <= issue & (rd_cnt == '0);
      rd_eof   <= issue & (rd_cnt == LAST_CNT);
      ovf      <= drop;
    end
  end

`ifdef SAMPLE_BUF_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 16'h0000;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'h0001;
    end
  end
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sample_buf_ctrl.sv
// Directed bench for sample_buf_ctrl: models the two dual-port RAMs and checks the block stream.
module tb_sample_buf_ctrl;
  localparam int DW  = 16;
  localparam int BLK = 256;
  localparam int AW  = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din_i = '0, din_q = '0;
  logic          din_valid = 1'b0;
  logic          om_ready = 1'b0;
  logic          we, rd_valid, rd_sof, rd_eof, ovf;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a_i, din_a_q;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sample_buf_ctrl #(.DW(DW), .BLK_LEN(BLK), .AW(AW)) dut (
    .clk(clk), .rst(rst), .din_i(din_i), .din_q(din_q), .din_valid(din_valid),
    .we(we), .addr_a(addr_a), .din_a_i(din_a_i), .din_a_q(din_a_q), .addr_b(addr_b),
    .om_ready(om_ready), .rd_valid(rd_valid), .rd_sof(rd_sof), .rd_eof(rd_eof),
    .ovf(ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port RAM model: synchronous write on A, one-cycle registered read on B.
  logic [DW-1:0] mem_i [0:(1<<AW)-1];
  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdat_i, rdat_q;
  logic [AW-1:0] raddr_q;
  always @(posedge clk) begin
    if (we) begin
      mem_i[addr_a] <= din_a_i;
      mem_q[addr_a] <= din_a_q;
    end
    rdat_i  <= mem_i[addr_b];
    rdat_q  <= mem_q[addr_b];
    raddr_q <= addr_b;
  end

  // Observed read stream and write-side bookkeeping, sampled mid-cycle.
  logic [DW-1:0] q_i[$], q_q[$];
  logic          q_sof[$], q_eof[$];
  logic [AW-1:0] q_addr[$];
  int            q_cyc[$];
  int            wr_tot = 0, ovf_cnt = 0, wa_bad = 0, ra_bad = 0, full_viol = 0, last_we_cyc = 0;
  logic [AW-1:0] exp_wa = '0, exp_ra = '0, last_wa = '0, last_ra = '0;
  logic [1:0]    tb_full = 2'b00;
  int            bank_wcnt [2] = '{0, 0};
  logic          seen_wa_mid = 1'b0, seen_wa_wrap = 1'b0, seen_ra_mid = 1'b0, seen_ra_wrap = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_wa       <= '0;
      exp_ra       <= '0;
      tb_full      <= 2'b00;
      bank_wcnt[0] <= 0;
      bank_wcnt[1] <= 0;
    end else begin
      if (ovf) ovf_cnt <= ovf_cnt + 1;
      if (we) begin
        wr_tot      <= wr_tot + 1;
        last_we_cyc <= cyc;
        last_wa     <= addr_a;
        exp_wa      <= addr_a + 1'b1;
        if (tb_full[addr_a[AW-1]]) full_viol <= full_viol + 1;
        if (addr_a !== exp_wa) wa_bad <= wa_bad + 1;
        if (addr_a == 9'd256 && last_wa == 9'd255) seen_wa_mid <= 1'b1;
        if (addr_a == 9'd0 && last_wa == 9'd511) seen_wa_wrap <= 1'b1;
        if (bank_wcnt[addr_a[AW-1]] == BLK - 1) begin
          bank_wcnt[addr_a[AW-1]] <= 0;
          tb_full[addr_a[AW-1]]   <= 1'b1;
        end else begin
          bank_wcnt[addr_a[AW-1]] <= bank_wcnt[addr_a[AW-1]] + 1;
        end
      end
      if (rd_valid) begin
        q_i.push_back(rdat_i);
        q_q.push_back(rdat_q);
        q_sof.push_back(rd_sof);
        q_eof.push_back(rd_eof);
        q_addr.push_back(raddr_q);
        q_cyc.push_back(cyc);
        last_ra <= raddr_q;
        exp_ra  <= raddr_q + 1'b1;
        if (raddr_q !== exp_ra) ra_bad <= ra_bad + 1;
        if (raddr_q == 9'd256 && last_ra == 9'd255) seen_ra_mid <= 1'b1;
        if (raddr_q == 9'd0 && last_ra == 9'd511) seen_ra_wrap <= 1'b1;
        if (rd_eof) tb_full[raddr_q[AW-1]] <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; din_valid = 1'b0; om_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({we, rd_valid, rd_sof, rd_eof, ovf} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got we/valid/sof/eof/ovf=%b want 00000", {we, rd_valid, rd_sof, rd_eof, ovf});
    end
    checks++;
    if ({addr_a, addr_b, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_addr got addr_a=%0d addr_b=%0d drop_cnt=%0d want 0", addr_a, addr_b, drop_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_continuous();
    int base = q_i.size();
    int bad_data = 0, bad_mark = 0, bad_cont = 0;
    om_ready = 1'b1;
    for (int k = 0; k < 2*BLK; k++) begin
      din_valid = 1'b1; din_i = DW'(k); din_q = ~DW'(k);
      tick();
    end
    din_valid = 1'b0;
    for (int t = 0; t < 1000 && q_i.size() < base + 2*BLK; t++) tick();
    checks++;
    if (q_i.size() - base != 2*BLK) begin
      errors++;
      $display("FAIL cont_count got %0d want %0d", q_i.size() - base, 2*BLK);
    end else begin
      for (int k = 0; k < 2*BLK; k++) begin
        if (q_i[base+k] !== DW'(k) || q_q[base+k] !== ~DW'(k) || q_addr[base+k] !== AW'(k)) bad_data++;
        if (q_sof[base+k] !== (k == 0 || k == BLK)) bad_mark++;
        if (q_eof[base+k] !== (k == BLK-1 || k == 2*BLK-1)) bad_mark++;
        if (k != BLK-1 && k != 2*BLK-1 && q_cyc[base+k+1] - q_cyc[base+k] != 1) bad_cont++;
      end
      checks++;
      if (bad_data != 0) begin errors++; $display("FAIL cont_data got %0d bad samples want 0", bad_data); end
      checks++;
      if (bad_mark != 0) begin errors++; $display("FAIL cont_markers got %0d bad markers want 0", bad_mark); end
      checks++;
      if (bad_cont != 0) begin errors++; $display("FAIL cont_gapless got %0d breaks want 0", bad_cont); end
      checks++;
      if (q_cyc[base+BLK] - q_cyc[base+BLK-1] != 3) begin
        errors++;
        $display("FAIL cont_block_gap got eof-to-sof %0d cycles want 3", q_cyc[base+BLK] - q_cyc[base+BLK-1]);
      end
    end
  endtask

  task automatic test_stall();
    int base = q_i.size();
    int n_sof = 0, n_eof = 0, bad = 0;
    for (int k = 0; k < BLK; k++) begin
      din_valid = 1'b1; din_i = DW'(k); din_q = ~DW'(k);
      om_ready = k[0];
      tick();
    end
    din_valid = 1'b0;
    for (int t = 0; t < 2000 && q_i.size() < base + BLK; t++) begin
      om_ready = ~om_ready;
      tick();
    end
    om_ready = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    checks++;
    if (q_i.size() - base != BLK) begin
      errors++;
      $display("FAIL stall_count got %0d want %0d", q_i.size() - base, BLK);
    end else begin
      for (int k = 0; k < BLK; k++) begin
        if (q_sof[base+k]) n_sof++;
        if (q_eof[base+k]) n_eof++;
        if (q_i[base+k] !== DW'(k) || q_q[base+k] !== ~DW'(k)) bad++;
      end
      checks++;
      if (n_sof != 1 || n_eof != 1 || !q_sof[base] || !q_eof[base+BLK-1]) begin
        errors++;
        $display("FAIL stall_markers got sof=%0d eof=%0d want 1 each at ends", n_sof, n_eof);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stall_order got %0d bad samples want 0", bad); end
    end
  endtask

  task automatic test_gapped();
    int base, bad = 0;
    apply_reset();
    om_ready = 1'b1;
    base = q_i.size();
    for (int k = 0; k < BLK; k++) begin
      din_valid = 1'b1; din_i = DW'(k + 'h200); din_q = DW'(k);
      tick();
      din_valid = 1'b0;
      tick(); tick();
    end
    checks++;
    if (q_i.size() != base) begin
      errors++;
      $display("FAIL gap_early_read got %0d reads want 0", q_i.size() - base);
    end
    for (int t = 0; t < 1000 && q_i.size() < base + BLK; t++) tick();
    checks++;
    if (q_i.size() - base != BLK) begin
      errors++;
      $display("FAIL gap_count got %0d want %0d", q_i.size() - base, BLK);
    end else begin
      checks++;
      if (q_cyc[base] - last_we_cyc != 3) begin
        errors++;
        $display("FAIL gap_latency got %0d cycles from last write to first read want 3", q_cyc[base] - last_we_cyc);
      end
      for (int k = 0; k < BLK; k++)
        if (q_i[base+k] !== DW'(k + 'h200) || q_addr[base+k] !== AW'(k)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL gap_data got %0d bad samples want 0", bad); end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset();
    base = q_i.size();
    for (int k = 0; k < BLK; k++) begin
      din_valid = 1'b1; din_i = DW'(k); din_q = DW'(k);
      tick();
    end
    din_valid = 1'b0;
    om_ready = 1'b1;
    for (int t = 0; t < 500 && q_i.size() < base + 100; t++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", rd_valid); end
    checks++;
    if ({we, rd_sof, rd_eof, ovf, addr_a, addr_b} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got we=%b sof=%b eof=%b ovf=%b addr_a=%0d addr_b=%0d want all 0",
               we, rd_sof, rd_eof, ovf, addr_a, addr_b);
    end
    tick();
    rst = 1'b0;
    tick();
    base = q_i.size();
    for (int k = 0; k < BLK; k++) begin
      din_valid = 1'b1; din_i = DW'(k + 'h300); din_q = DW'(k);
      tick();
    end
    din_valid = 1'b0;
    for (int t = 0; t < 1000 && q_i.size() < base + BLK; t++) tick();
    for (int t = 0; t < 10; t++) tick();
    checks++;
    if (q_i.size() - base != BLK) begin
      errors++;
      $display("FAIL midrst_count got %0d want %0d", q_i.size() - base, BLK);
    end else begin
      checks++;
      if (!q_sof[base] || q_addr[base] !== '0 || q_i[base] !== 16'h0300) begin
        errors++;
        $display("FAIL midrst_first got sof=%b addr=%0d data=%h want 1 0 0300", q_sof[base], q_addr[base], q_i[base]);
      end
    end
  endtask

  task automatic test_overflow();
    int base, o_base, w_base, bad = 0;
    logic [15:0] exp_drop;
`ifdef SAMPLE_BUF_DROP_CNT_EN
    exp_drop = 16'd88;
`else
    exp_drop = 16'd0;
`endif
    apply_reset();
    base = q_i.size(); o_base = ovf_cnt; w_base = wr_tot;
    for (int k = 0; k < 600; k++) begin
      din_valid = 1'b1; din_i = DW'(k); din_q = ~DW'(k);
      tick();
    end
    din_valid = 1'b0;
    tick(); tick();
    checks++;
    if (wr_tot - w_base != 512) begin errors++; $display("FAIL ovf_writes got %0d want 512", wr_tot - w_base); end
    checks++;
    if (ovf_cnt - o_base != 88) begin errors++; $display("FAIL ovf_pulses got %0d want 88", ovf_cnt - o_base); end
    checks++;
    if (drop_cnt !== exp_drop) begin errors++; $display("FAIL ovf_drop_cnt got %0d want %0d", drop_cnt, exp_drop); end
    checks++;
    if (q_i.size() != base) begin errors++; $display("FAIL ovf_no_read got %0d reads want 0", q_i.size() - base); end
    om_ready = 1'b1;
    for (int t = 0; t < 1000 && q_i.size() < base + BLK; t++) tick();
    din_valid = 1'b1; din_i = 16'h0777; din_q = 16'h0777;
    #1;
    checks++;
    if (we !== 1'b1 || addr_a !== '0) begin
      errors++;
      $display("FAIL ovf_resume got we=%b addr_a=%0d want 1 0", we, addr_a);
    end
    tick();
    din_valid = 1'b0;
    for (int t = 0; t < 1000 && q_i.size() < base + 2*BLK; t++) tick();
    checks++;
    if (q_i.size() - base != 2*BLK) begin
      errors++;
      $display("FAIL ovf_drain_count got %0d want %0d", q_i.size() - base, 2*BLK);
    end else begin
      for (int k = 0; k < 2*BLK; k++)
        if (q_i[base+k] !== DW'(k)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL ovf_drain_data got %0d bad samples want 0", bad); end
    end
  endtask

  task automatic test_bank_boundary();
    checks++;
    if (wa_bad != 0) begin errors++; $display("FAIL bank_wr_seq got %0d address jumps want 0", wa_bad); end
    checks++;
    if (ra_bad != 0) begin errors++; $display("FAIL bank_rd_seq got %0d address jumps want 0", ra_bad); end
    checks++;
    if (full_viol != 0) begin errors++; $display("FAIL bank_full_write got %0d writes into full bank want 0", full_viol); end
    checks++;
    if ({seen_wa_mid, seen_wa_wrap, seen_ra_mid, seen_ra_wrap} !== 4'b1111) begin
      errors++;
      $display("FAIL bank_transitions got wr255>256=%b wr511>0=%b rd255>256=%b rd511>0=%b want 1111",
               seen_wa_mid, seen_wa_wrap, seen_ra_mid, seen_ra_wrap);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_continuous();
    test_stall();
    test_gapped();
    test_reset_mid();
    test_overflow();
    test_bank_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
